burst_detect: RTL

Receive-side counterpart to the burst generator. It watches the raw received carrier (nominally 13.5 MHz square bursts sampled at 81 MHz) and synchronises it. It qualifies a burst once a minimum number of in-tolerance carrier periods has been seen, then reports the burst start, its duration in carrier cycles, and any malformed period. It sits between the receive comparator pin and the delay line's edge/timestamp input, replacing plain level detection with carrier-aware detection.

---
 rtl/delay_line_pkg.sv | 19 +
 rtl/sync_ff.sv | 29 ++
 rtl/burst_detect.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared carrier constants, FSM states and sizing helper for the burst generator/detector pair
package delay_line_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } bd_state_e;

    localparam int DEF_CLKS_PER_HALF_PERIOD = 3;
    localparam int DEF_TOLERANCE            = 1;
    localparam int DEF_MIN_PULSES           = 3;
    localparam int DEF_COUNT_W              = 8;

    function automatic int pc_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_ff (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/burst_detect.sv
// rtl/burst_detect.sv - carrier-aware burst qualifier with period check and edge count
// Optional: BURST_DETECT_GLITCH_FILTER_EN rejects 1-clock glitches on the synchronised input.
module burst_detect
    import delay_line_pkg::*;
#(
    parameter int CLKS_PER_HALF_PERIOD = DEF_CLKS_PER_HALF_PERIOD,
    parameter int TOLERANCE            = DEF_TOLERANCE,
    parameter int MIN_PULSES           = DEF_MIN_PULSES,
    parameter int COUNT_W              = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               in,
    output logic               detect,
    output logic               active,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic               error
);

    localparam int P      = 2 * CLKS_PER_HALF_PERIOD;
    localparam int LIMIT  = P + TOLERANCE + 1;
    localparam int PC_W   = pc_width(LIMIT);
    localparam int WIN_LO = P - TOLERANCE;
    localparam int WIN_HI = P + TOLERANCE;

    localparam logic [PC_W-1:0]    LIMIT_PC  = PC_W'(LIMIT);
    localparam logic [PC_W:0]      WIN_LO_W  = (PC_W+1)'(WIN_LO);
    localparam logic [PC_W:0]      WIN_HI_W  = (PC_W+1)'(WIN_HI);
    localparam logic [PC_W:0]      LIMIT_W   = (PC_W+1)'(LIMIT);
    localparam logic [COUNT_W-1:0] CC_MAX    = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CC_ONE    = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] MIN_CC    = COUNT_W'(MIN_PULSES);

    logic in_sync;
    logic in_sync_d_q, in_sync_d_d;
    logic rise;

    sync_ff u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (in),
        .q       (in_sync)
    );

    assign in_sync_d_d = in_sync;

`ifdef BURST_DETECT_GLITCH_FILTER_EN
    // The filtered level follows in_sync only once two successive samples agree.
    logic filt_q, filt_d;

    assign filt_d = (in_sync == in_sync_d_q) ? in_sync : filt_q;
    assign rise   = filt_d & ~filt_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) filt_q <= 1'b0;
        else          filt_q <= filt_d;
    end
`else
    assign rise = in_sync & ~in_sync_d_q;
`endif

    bd_state_e          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [COUNT_W-1:0] cc_q, cc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               detect_q, detect_d;
    logic               active_q, active_d;
    logic               cv_q, cv_d;
    logic               err_q, err_d;

    logic [PC_W:0]      pc_inc;
    logic [COUNT_W-1:0] cc_inc;
    logic               in_win, early, timeout;

    always_comb begin
        pc_inc  = {1'b0, pc_q} + 1'b1;
        cc_inc  = (cc_q == CC_MAX) ? cc_q : cc_q + 1'b1;
        in_win  = (pc_inc >= WIN_LO_W) && (pc_inc <= WIN_HI_W);
        early   = pc_inc < WIN_LO_W;
        // In ACQUIRE/LOCKED pc never exceeds LIMIT-1, so pc+1 == LIMIT marks the timeout point.
        timeout = pc_inc == LIMIT_W;

        state_d  = state_q;
        pc_d     = (pc_q == LIMIT_PC) ? pc_q : pc_q + 1'b1;
        cc_d     = cc_q;
        count_d  = count_q;
        detect_d = 1'b0;
        cv_d     = 1'b0;
        err_d    = 1'b0;

        if (rise) pc_d = '0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    cc_d = CC_ONE;
                    if (MIN_PULSES <= 1) begin
                        state_d  = LOCKED;
                        detect_d = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                    end
                end
            end
            ACQUIRE: begin
                if (rise) begin
                    if (in_win) begin
                        cc_d = cc_inc;
                        if (cc_inc >= MIN_CC) begin
                            state_d  = LOCKED;
                            detect_d = 1'b1;
                        end
                    end else begin
                        cc_d = CC_ONE;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (in_win) begin
                        cc_d = cc_inc;
                    end else begin
                        // A late edge is the timeout; only an early one is malformed.
                        count_d = cc_q;
                        cv_d    = 1'b1;
                        err_d   = early;
                        cc_d    = CC_ONE;
                        state_d = ACQUIRE;
                    end
                end else if (timeout) begin
                    count_d = cc_q;
                    cv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = state_d == LOCKED;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            in_sync_d_q <= 1'b0;
            state_q     <= IDLE;
            pc_q        <= '0;
            cc_q        <= '0;
            count_q     <= '0;
            detect_q    <= 1'b0;
            active_q    <= 1'b0;
            cv_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            in_sync_d_q <= in_sync_d_d;
            state_q     <= state_d;
            pc_q        <= pc_d;
            cc_q        <= cc_d;
            count_q     <= count_d;
            detect_q    <= detect_d;
            active_q    <= active_d;
            cv_q        <= cv_d;
            err_q       <= err_d;
        end
    end

    assign detect      = detect_q;
    assign active      = active_q;
    assign count       = count_q;
    assign count_valid = cv_q;
    assign error       = err_q;

endmodule
